// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates one synchronous memory port between a processor requester (p_*)
//   and an I/O requester (io_*). One transfer at a time runs through
//   IDLE -> ISSUE -> (RDWAIT on reads) -> DONE -> IDLE. Every output is a register.
//
//   Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//     defined   : alternating priority on simultaneous requests, based on the
//                 last owner (which resets to I/O so the processor wins first)
//     undefined : fixed priority, the processor always wins
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   p_req/p_we/p_addr/p_wdata     processor request, write flag, address, data
//   p_gnt/p_ack                   processor owns the port / transfer done
//   io_req/io_we/io_addr/io_wdata I/O request, write flag, address, data
//   io_gnt/io_ack                 I/O owns the port / transfer done
//   rdata                         read data, updated only by reads
//   mem_addr/mem_wdata/mem_we     memory drive
//   mem_rdata                     memory read data, one cycle after mem_addr
//   busy                          high whenever the FSM is not in IDLE
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_ack,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic OWN_P  = 1'b0;
  localparam logic OWN_IO = 1'b1;

  logic [1:0]        r_state;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_rdata;
  logic              r_p_gnt;
  logic              r_io_gnt;
  logic              r_p_ack;
  logic              r_io_ack;
  logic              r_busy;

  logic              w_any_req;
  logic              w_win_io;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  assign w_any_req = p_req | io_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_owner;

  // I/O wins if it is alone, or if both ask and the processor had the last turn.
  assign w_win_io = io_req & (~p_req | (r_last_owner == OWN_P));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_owner <= OWN_IO;
    end else if ((r_state == S_IDLE) && w_any_req) begin
      r_last_owner <= w_win_io;
    end
  end
`else
  assign w_win_io = io_req & ~p_req;
`endif

  assign w_win_we    = w_win_io ? io_we    : p_we;
  assign w_win_addr  = w_win_io ? io_addr  : p_addr;
  assign w_win_wdata = w_win_io ? io_wdata : p_wdata;

  // The address/data output registers double as the request latch, so inputs
  // changing after the IDLE sample cannot disturb the transfer. The ack is
  // loaded on the DONE exit edge, so it is visible in the following IDLE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_P;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_rdata     <= '0;
      r_p_gnt     <= 1'b0;
      r_io_gnt    <= 1'b0;
      r_p_ack     <= 1'b0;
      r_io_ack    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_p_ack  <= 1'b0;
      r_io_ack <= 1'b0;
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner     <= w_win_io;
            r_we        <= w_win_we;
            r_mem_addr  <= w_win_addr;
            r_mem_wdata <= w_win_wdata;
            r_mem_we    <= w_win_we;
            r_p_gnt     <= ~w_win_io;
            r_io_gnt    <= w_win_io;
            r_busy      <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= r_we ? S_DONE : S_RDWAIT;
        end
        S_RDWAIT: begin
          r_rdata <= mem_rdata;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_p_ack  <= (r_owner == OWN_P);
          r_io_ack <= (r_owner == OWN_IO);
          r_p_gnt  <= 1'b0;
          r_io_gnt <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign p_gnt     = r_p_gnt;
  assign io_gnt    = r_io_gnt;
  assign p_ack     = r_p_ack;
  assign io_ack    = r_io_ack;
  assign rdata     = r_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign busy      = r_busy;

endmodule
